// File: rtl/small_mips_pkg.sv
// small_mips_pkg: shared widths and the fetch-state type for the small MIPS front end.
//   INSTR_W      instruction word width
//   OPCODE_W     opcode field width
//   ADDR_W_DEF   default instruction ROM word-address width
//   fetch_state_t  FS_RUN (fetching) / FS_DONE (halted)
package small_mips_pkg;
  localparam int INSTR_W = 32;
  localparam int OPCODE_W = 6;
  localparam int ADDR_W_DEF = 8;
  typedef enum logic {FS_RUN, FS_DONE} fetch_state_t;
endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: PC-driven fetch stage with valid/ready output, redirect and halt at LAST_ADDR.
//   i_clk, i_rst               clock, synchronous active-high reset
//   o_romAddr / i_romData      word address to the external ROM, combinational read data back
//   o_instr, o_pc, o_valid     held instruction, its address, and occupancy flag
//   i_ready                    decoder accepts the held word this cycle
//   i_redirect, i_redirectAddr flush the held word and reload the PC
//   o_done                     halted and output empty
//   o_fetchCount               handshake counter (saturating), only with INSTR_FETCH_PERF_EN defined
module instr_fetch
  import small_mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LAST_ADDR = 12
) (
`ifdef INSTR_FETCH_PERF_EN
  output logic [15:0]        o_fetchCount,
`endif
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [ADDR_W-1:0]  o_romAddr,
  input  logic [INSTR_W-1:0] i_romData,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_valid,
  input  logic               i_ready,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirectAddr,
  output logic               o_done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);
  fetch_state_t state;
  logic [ADDR_W-1:0] pc;
  logic load, handshake;
  assign o_romAddr = pc;
  assign handshake = o_valid & i_ready;
  assign load = (state == FS_RUN) & ~i_redirect & (~o_valid | i_ready);
  assign o_done = (state == FS_DONE) & ~o_valid;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc <= '0;
      o_pc <= '0;
      o_instr <= '0;
      o_valid <= 1'b0;
      state <= FS_RUN;
    end else if (i_redirect) begin
      // a handshake in this cycle still completes; the held word is simply dropped
      pc <= i_redirectAddr;
      o_valid <= 1'b0;
      state <= (i_redirectAddr > LAST) ? FS_DONE : FS_RUN;
    end else if (load) begin
      o_instr <= i_romData;
      o_pc <= pc;
      o_valid <= 1'b1;
      pc <= pc + ADDR_W'(1);
      state <= (pc == LAST) ? FS_DONE : FS_RUN;
    end else if (handshake) begin
      o_valid <= 1'b0;
    end
  end
`ifdef INSTR_FETCH_PERF_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) o_fetchCount <= '0;
    else if (handshake && o_fetchCount != 16'hFFFF) o_fetchCount <= o_fetchCount + 16'd1;
  end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios with a cycle model of the fetch contract checked every cycle.
module tb_instr_fetch;
  localparam int LAST = 12;
  logic clk = 1'b0;
  logic rst, ready, redirect;
  logic [7:0] redirect_addr, rom_addr, o_pc;
  logic [31:0] rom_data, o_instr;
  logic o_valid, o_done;
  int passed = 0, total = 0;
`ifdef INSTR_FETCH_PERF_EN
  logic [15:0] fetch_count;
`endif
  always #5 clk = ~clk;
  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return {8'hC0, a, ~a, a ^ 8'h5A};
  endfunction
  assign rom_data = rom_word(rom_addr);
  instr_fetch dut (
`ifdef INSTR_FETCH_PERF_EN
    .o_fetchCount(fetch_count),
`endif
    .i_clk(clk), .i_rst(rst), .o_romAddr(rom_addr), .i_romData(rom_data),
    .o_instr(o_instr), .o_pc(o_pc), .o_valid(o_valid), .i_ready(ready),
    .i_redirect(redirect), .i_redirectAddr(redirect_addr), .o_done(o_done)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // model: next address to fetch, the held word (if any), and whether fetching has stopped
  int m_next, m_cnt;
  bit m_hv, m_halt, m_live;
  int m_hpc;
  always @(posedge clk) begin
    if (rst) begin
      m_next = 0; m_hv = 0; m_hpc = 0; m_halt = 0; m_cnt = 0; m_live = 1;
    end else if (m_live) begin
      if (m_hv && ready && m_cnt < 65535) m_cnt++;
      if (redirect) begin
        m_hv = 0; m_next = redirect_addr; m_halt = redirect_addr > LAST;
      end else if (!m_halt && (!m_hv || ready)) begin
        m_hv = 1; m_hpc = m_next; m_halt = (m_next == LAST); m_next = (m_next + 1) % 256;
      end else if (m_hv && ready) m_hv = 0;
    end
  end
  always @(negedge clk) if (m_live) begin
    chk("m_valid", {31'd0, o_valid}, {31'd0, m_hv});
    chk("m_done", {31'd0, o_done}, {31'd0, m_halt && !m_hv});
    chk("m_romaddr", {24'd0, rom_addr}, 32'(m_next));
    if (m_hv) begin
      chk("m_pc", {24'd0, o_pc}, 32'(m_hpc));
      chk("m_instr", o_instr, rom_word(8'(m_hpc)));
    end
`ifdef INSTR_FETCH_PERF_EN
    chk("m_count", {16'd0, fetch_count}, 32'(m_cnt));
`endif
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; ready = 0; redirect = 0; redirect_addr = 0;
    step(2);
    chk("rst_valid", {31'd0, o_valid}, 0);
    chk("rst_pc", {24'd0, o_pc}, 0);
    chk("rst_instr", o_instr, 0);
    chk("rst_done", {31'd0, o_done}, 0);
    chk("rst_romaddr", {24'd0, rom_addr}, 0);
    // full stream at one word per cycle
    rst = 0; ready = 1;
    step(1);
    for (int k = 0; k <= LAST; k++) begin
      chk("stream_valid", {31'd0, o_valid}, 1);
      chk("stream_pc", {24'd0, o_pc}, 32'(k));
      chk("stream_instr", o_instr, rom_word(8'(k)));
      step(1);
    end
    chk("end_valid", {31'd0, o_valid}, 0);
    chk("end_done", {31'd0, o_done}, 1);
`ifdef INSTR_FETCH_PERF_EN
    chk("perf_13", {16'd0, fetch_count}, 13);
`endif
    // stall: ready low for five cycles after the first load
    rst = 1; step(1);
    rst = 0; ready = 0; step(1);
    chk("stall_first", {24'd0, o_pc}, 0);
    step(5);
    chk("stall_valid", {31'd0, o_valid}, 1);
    chk("stall_pc", {24'd0, o_pc}, 0);
    chk("stall_instr", o_instr, 32'hC000FF5A);
    chk("stall_romaddr", {24'd0, rom_addr}, 1);
    // redirect to 3 while word 6 is valid and accepted
    ready = 1; step(6);
    chk("redir_pre", {24'd0, o_pc}, 6);
    redirect = 1; redirect_addr = 3; step(1);
    chk("redir_flush", {31'd0, o_valid}, 0);
    redirect = 0; step(1);
    chk("redir_pc", {24'd0, o_pc}, 3);
    chk("redir_valid", {31'd0, o_valid}, 1);
`ifdef INSTR_FETCH_PERF_EN
    chk("perf_keep", {16'd0, fetch_count}, 7);
`endif
    // reset mid-stream at word 7
    step(4);
    chk("mid_pre", {24'd0, o_pc}, 7);
    rst = 1; step(1);
    chk("mid_valid", {31'd0, o_valid}, 0);
    chk("mid_romaddr", {24'd0, rom_addr}, 0);
    rst = 0; step(1);
    chk("mid_restart", {24'd0, o_pc}, 0);
    // run to DONE, redirect back into range, then beyond LAST
    step(LAST + 1);
    chk("done_a", {31'd0, o_done}, 1);
    redirect = 1; redirect_addr = 2; step(1);
    chk("done_redir_done", {31'd0, o_done}, 0);
    redirect = 0; step(1);
    chk("done_refetch", {24'd0, o_pc}, 2);
    step(LAST - 1);
    chk("done_b", {31'd0, o_done}, 1);
    redirect = 1; redirect_addr = 20; step(1);
    chk("far_done", {31'd0, o_done}, 1);
    redirect = 0; step(3);
    chk("far_hold", {31'd0, o_valid}, 0);
    // irregular ready with a redirect under a stalled word
    redirect = 1; redirect_addr = 5; step(1);
    redirect = 0;
    for (int i = 0; i < 20; i++) begin
      ready = (i % 3) != 0;
      redirect = (i == 9);
      redirect_addr = 8'd1;
      step(1);
    end
    redirect = 0; ready = 1; step(LAST + 2);
    chk("tail_done", {31'd0, o_done}, 1);
    m_live = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the instruction ROM word-address width.
REQ-002 The block SHALL have parameter LAST_ADDR, default 12, giving the highest ROM address fetched before halting.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port o_romAddr, output, ADDR_W bits: word address to the external rom instance.
REQ-006 The block SHALL have port i_romData, input, 32 bits: rom read data, combinational in o_romAddr.
REQ-007 The block SHALL have port o_instr, output, 32 bits: registered instruction word for the decoder.
REQ-008 The block SHALL have port o_pc, output, ADDR_W bits: address of the word held in o_instr.
REQ-009 The block SHALL have port o_valid, output, 1 bit: o_instr and o_pc hold an unconsumed instruction.
REQ-010 The block SHALL have port i_ready, input, 1 bit: the decoder accepts o_instr this cycle.
REQ-011 The block SHALL have port i_redirect, input, 1 bit: branch or jump taken; flushes and reloads the PC.
REQ-012 The block SHALL have port i_redirectAddr, input, ADDR_W bits: new PC when i_redirect=1.
REQ-013 The block SHALL have port o_done, output, 1 bit: the block is halted and its output is empty.

Function
REQ-014 The block SHALL have FSM states RUN and DONE.
REQ-015 The block SHALL drive o_romAddr combinationally from the internal pc register.
REQ-016 Load SHALL occur when state=RUN, i_redirect=0 and (o_valid=0 or i_ready=1).
REQ-017 On load: o_instr<=i_romData, o_pc<=pc, o_valid<=1, pc<=pc+1 (modulo 2^ADDR_W).
REQ-018 A handshake SHALL be o_valid & i_ready; the block SHALL hold o_instr, o_pc and o_valid stable while o_valid=1 and i_ready=0.
REQ-019 Throughput SHALL be one instruction per cycle while i_ready=1; first o_valid occurs one cycle after reset release.
REQ-020 A load from pc=LAST_ADDR SHALL move the FSM RUN->DONE; in DONE no loads occur and o_valid clears on the next handshake.
REQ-021 o_done SHALL equal (state=DONE) & ~o_valid.
REQ-022 i_redirect=1 SHALL override loading: o_valid<=0, pc<=i_redirectAddr, state<=RUN, from either state.
REQ-023 If i_redirectAddr>LAST_ADDR, the block SHALL set state<=DONE instead of RUN.
REQ-024 Simultaneous handshake and redirect: the handshake SHALL count as completed, the held word SHALL be discarded, and no new word SHALL load that cycle.
REQ-025 The block SHALL perform no ROM bounds check other than LAST_ADDR, and pc wrap SHALL NOT occur with the default parameters.

Reset
REQ-026 While i_rst=1 at a clock edge: pc=0, o_pc=0, o_instr=0, o_valid=0, state=RUN; o_done=0 follows from these values.
REQ-027 Reset SHALL take priority over i_redirect and handshakes, and SHALL abort any in-flight instruction mid-operation.

Configuration
REQ-028 Macro INSTR_FETCH_PERF_EN defined: the block SHALL add output o_fetchCount, 16 bits, counting handshakes, saturating at 16'hFFFF, reset to 0, not cleared by redirect.
REQ-029 Macro INSTR_FETCH_PERF_EN undefined: the port and counter SHALL be absent, with all other behaviour identical.

Structure
REQ-030 Package small_mips_pkg SHALL hold INSTR_W=32, OPCODE_W=6, default ADDR_W and the fetch-state enum type.
REQ-031 The block SHALL have no sub-module; the ROM SHALL remain an external rom instance connected at the top level.

Verification
REQ-032 Reset, then i_ready=1 constantly -> o_pc = 0,1,...,12 on consecutive cycles, o_instr matches rom words, o_done=1 the cycle after pc 12 is accepted.
REQ-033 i_ready held 0 for 5 cycles after the first load -> o_pc=0 and o_instr stable, o_valid=1, pc not advanced.
REQ-034 i_redirect=1 with i_redirectAddr=3 while o_pc=6 is valid -> next cycle o_valid=0; following cycle o_pc=3.
REQ-035 In DONE, i_redirect with addr 2 -> state RUN, o_done=0, words 2..12 re-fetched; redirect with addr 20 -> o_done=1 next cycle.
REQ-036 i_rst=1 asserted mid-stream at o_pc=7 -> next cycle o_valid=0, pc=0; stream restarts at address 0.
REQ-037 With INSTR_FETCH_PERF_EN, a full run of REQ-032 -> o_fetchCount=13; redirect then does not clear it.
